// File: rtl/uart_tx_arbiter_if.sv
// Bundle between NUM_REQ packet sources, the arbiter and the UART TX FIFO write port.
// The master side drives requests and FIFO status. The slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     tx_full;
  logic                     write_uart;
  logic [WIDTH-1:0]         write_data;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     pkt_done;
  logic                     pkt_abort;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, write_uart, write_data, grant_id, busy, pkt_done, pkt_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, write_uart, write_data, grant_id, busy, pkt_done, pkt_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO among NUM_REQ sources.
// Optionally emits a source tag byte ahead of each packet and aborts packets whose owner stalls.
module uart_tx_arbiter #(
  parameter int               NUM_REQ      = 4,
  parameter int               WIDTH        = 8,
  parameter bit               TAG_EN       = 1'b1,
  parameter logic [WIDTH-1:0] TAG_BASE     = 8'hF0,
  parameter int               STALL_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STALL_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_t;

  state_t             state;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    last_grant;
  logic [CNT_W-1:0]   stall_cnt;
  logic               busy;
  logic               pkt_done;
  logic               pkt_abort;

  logic               sel_valid;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   tag_byte;
  logic               xfer;
  logic [NUM_REQ-1:0] ready;
  logic               wr;
  logic [WIDTH-1:0]   wr_data;

  // First requester after last_grant in circular order; the loop runs backwards so the nearest wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[ID_W'(idx)]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign sel_valid = bus.req_valid[grant_id];
  assign sel_last  = bus.req_last[grant_id];
  assign sel_data  = bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
  assign tag_byte  = {TAG_BASE[WIDTH-1:4], 4'(grant_id)};
  assign xfer      = (state == STREAM) && sel_valid && !bus.tx_full;

  always_comb begin
    ready   = '0;
    wr      = 1'b0;
    wr_data = '0;
    case (state)
      TAG: begin
        wr      = !bus.tx_full;
        wr_data = tag_byte;
      end
      STREAM: begin
        ready[grant_id] = !bus.tx_full;
        wr              = xfer;
        wr_data         = sel_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      stall_cnt  <= '0;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id  <= rr_pick(bus.req_valid, last_grant);
            stall_cnt <= '0;
            busy      <= 1'b1;
            state     <= TAG_EN ? TAG : STREAM;
          end
        end
        TAG: begin
          if (!bus.tx_full) state <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (sel_last) begin
              last_grant <= grant_id;
              busy       <= 1'b0;
              pkt_done   <= 1'b1;
              state      <= IDLE;
            end
          end else if (!bus.tx_full) begin
            // Full-FIFO cycles are not the owner's fault, so only unblocked idle cycles count.
            if (stall_cnt == CNT_W'(STALL_CYCLES - 1)) begin
              last_grant <= grant_id;
              busy       <= 1'b0;
              pkt_abort  <= 1'b1;
              state      <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.write_uart = wr;
  assign bus.write_data = wr_data;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = busy;
  assign bus.pkt_done   = pkt_done;
  assign bus.pkt_abort  = pkt_abort;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a packet-level model.
// Sources are queues of {last, byte}; the model predicts grants, tags, bytes and done/abort pulses.
module tb_uart_tx_arbiter;
  localparam int         N     = 4;
  localparam int         W     = 8;
  localparam int         SC    = 16;
  localparam logic [7:0] TBASE = 8'hF0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .TAG_EN(1'b1), .TAG_BASE(TBASE), .STALL_CYCLES(SC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] sq [N][$];
  logic [7:0] cap [$];
  int         pops [N];
  logic [N-1:0] en;
  logic       full;
  bit         m_busy, m_tag_pend, exp_done, exp_abort;
  int         m_owner, m_last, m_gid, m_stall;
  int         done_cnt = 0;
  int         abort_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_pkt(input int src, input int len, input bit rnd, input logic [7:0] base);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = rnd ? 8'($urandom) : 8'(base + k);
      sq[src].push_back({(k == len - 1), d});
    end
  endtask

  // One clock: drive sources from their queues, check DUT against the model, advance the model.
  task automatic cycle();
    logic [N-1:0] v, rdy_exp;
    logic         wu_exp;
    logic [7:0]   wd_exp;
    logic [8:0]   b;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      v[i] = en[i] && (sq[i].size() > 0);
      bus.req_valid[i] = v[i];
      bus.req_data[i*W +: W] = v[i] ? sq[i][0][7:0] : 8'($urandom);
      bus.req_last[i] = v[i] ? sq[i][0][8] : 1'($urandom);
    end
    bus.tx_full = full;
    #1;
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("pkt_done", 32'(bus.pkt_done), 32'(exp_done));
    check("pkt_abort", 32'(bus.pkt_abort), 32'(exp_abort));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    rdy_exp = '0;
    wu_exp  = 1'b0;
    wd_exp  = '0;
    if (m_busy && !full) begin
      if (m_tag_pend) begin
        wu_exp = 1'b1;
        wd_exp = (TBASE & 8'hF0) | 8'(m_owner & 15);
      end else begin
        rdy_exp[m_owner] = 1'b1;
        if (v[m_owner]) begin
          wu_exp = 1'b1;
          wd_exp = sq[m_owner][0][7:0];
        end
      end
    end
    check("req_ready", 32'(bus.req_ready), 32'(rdy_exp));
    check("write_uart", 32'(bus.write_uart), 32'(wu_exp));
    if (bus.write_uart) begin
      cap.push_back(bus.write_data);
      if (wu_exp) check("write_data", 32'(bus.write_data), 32'(wd_exp));
    end
    if (bus.pkt_done) done_cnt++;
    if (bus.pkt_abort) abort_cnt++;
    exp_done  = 1'b0;
    exp_abort = 1'b0;
    if (!m_busy) begin
      if (|v) begin
        m_owner = rr_next(v, m_last);
        m_gid = m_owner;
        m_busy = 1'b1;
        m_tag_pend = 1'b1;
        m_stall = 0;
      end
    end else if (!full) begin
      if (m_tag_pend) begin
        m_tag_pend = 1'b0;
      end else if (v[m_owner]) begin
        b = sq[m_owner].pop_front();
        pops[m_owner]++;
        m_stall = 0;
        if (b[8]) begin
          m_busy = 1'b0;
          m_last = m_owner;
          exp_done = 1'b1;
        end
      end else begin
        m_stall++;
        if (m_stall == SC) begin
          m_busy = 1'b0;
          m_last = m_owner;
          exp_abort = 1'b1;
          while (sq[m_owner].size() > 0) begin
            b = sq[m_owner].pop_front();
            if (b[8]) break;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    en = '0;
    full = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_full = 1'b0;
    for (int i = 0; i < N; i++) sq[i].delete();
    m_busy = 1'b0; m_tag_pend = 1'b0; m_owner = 0; m_last = N - 1; m_gid = 0; m_stall = 0;
    exp_done = 1'b0; exp_abort = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_write_uart", 32'(bus.write_uart), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_pkt_done", 32'(bus.pkt_done), 0);
    check("rst_pkt_abort", 32'(bus.pkt_abort), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_until_pops(input int src, input int n);
    int target = pops[src] + n;
    int c = 0;
    while (pops[src] < target && c < 200) begin
      cycle();
      c++;
    end
    check("pops_timeout", 32'(pops[src] >= target), 1);
  endtask

  task automatic drain();
    int n = 0;
    en = '1;
    full = 1'b0;
    while ((m_busy || !all_empty()) && n < 2000) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 1);
    cycle();
    cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, a0, n;
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < N; i++) pops[i] = 0;
    do_reset();

    // Single packet from source 2 gets its tag in front.
    cap.delete();
    d0 = done_cnt;
    en = '1;
    push_pkt(2, 3, 1'b0, 8'hA1);
    drain();
    check("t1_len", 32'(cap.size()), 4);
    if (cap.size() == 4) begin
      check("t1_tag", 32'(cap[0]), 32'h F2);
      check("t1_b0", 32'(cap[1]), 32'h A1);
      check("t1_b1", 32'(cap[2]), 32'h A2);
      check("t1_b2", 32'(cap[3]), 32'h A3);
    end
    check("t1_done_pulses", 32'(done_cnt - d0), 1);

    // Fairness among three continuously requesting sources.
    do_reset();
    cap.delete();
    for (int p = 0; p < 2; p++) begin
      push_pkt(0, 2, 1'b0, 8'(8'h00 + p*2));
      push_pkt(1, 2, 1'b0, 8'(8'h10 + p*2));
      push_pkt(3, 2, 1'b0, 8'(8'h30 + p*2));
    end
    en = '1;
    drain();
    check("t2_len", 32'(cap.size()), 18);
    if (cap.size() == 18)
      for (int k = 0; k < 6; k++) check("t2_tag_order", 32'(cap[3*k]), 32'(8'hF0 | 8'(order[k])));

    // Backpressure mid-packet must not lose or duplicate bytes.
    cap.delete();
    en = '1;
    push_pkt(1, 10, 1'b0, 8'h30);
    run_until_pops(1, 3);
    full = 1'b1;
    repeat (5) cycle();
    full = 1'b0;
    drain();
    check("t3_len", 32'(cap.size()), 11);
    if (cap.size() == 11) begin
      check("t3_tag", 32'(cap[0]), 32'hF1);
      for (int k = 0; k < 10; k++) check("t3_byte", 32'(cap[k+1]), 32'(8'h30 + k));
    end

    // Owner goes silent after two bytes: abort after SC idle cycles, then source 0 wins.
    a0 = abort_cnt;
    en = 4'b0010;
    push_pkt(1, 4, 1'b0, 8'h50);
    run_until_pops(1, 2);
    en = 4'b0001;
    push_pkt(0, 2, 1'b0, 8'h60);
    n = 0;
    while (abort_cnt == a0 && n < 40) begin
      cycle();
      n++;
    end
    check("t4_abort_cycle", 32'(n), 17);
    check("t4_abort_pulses", 32'(abort_cnt - a0), 1);
    cycle();
    check("t4_next_grant", 32'(bus.grant_id), 0);
    drain();

    // Idle owner while the FIFO is full must not trip the watchdog.
    cap.delete();
    a0 = abort_cnt;
    d0 = done_cnt;
    en = 4'b0010;
    push_pkt(1, 3, 1'b0, 8'h70);
    run_until_pops(1, 1);
    en = '0;
    full = 1'b1;
    repeat (40) cycle();
    check("t5_no_abort", 32'(abort_cnt - a0), 0);
    drain();
    check("t5_len", 32'(cap.size()), 4);
    check("t5_done", 32'(done_cnt - d0), 1);

    // Randomized traffic with random backpressure and valid gaps.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(99) < 85);
        if (sq[i].size() < 8 && $urandom_range(99) < 4) push_pkt(i, $urandom_range(6, 1), 1'b1, 8'h00);
      end
      full = ($urandom_range(99) < 15);
      cycle();
    end
    drain();

    // Reset in the middle of a packet clears outputs at once; source 0 wins afterwards.
    en = '1;
    push_pkt(2, 5, 1'b0, 8'h80);
    run_until_pops(2, 2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_write_uart", 32'(bus.write_uart), 0);
    check("t6_req_ready", 32'(bus.req_ready), 0);
    check("t6_busy", 32'(bus.busy), 0);
    do_reset();
    push_pkt(2, 1, 1'b0, 8'h90);
    push_pkt(0, 1, 1'b0, 8'hA0);
    en = '1;
    cycle();
    cycle();
    check("t6_first_grant", 32'(bus.grant_id), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
